// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the lab3 ALU sequencing controller.
package alu_seq_pkg;

    localparam int unsigned LAT_W = 4;
    localparam int unsigned STATE_W = 3;

    // FSM states; the encoding is exported on the debug LEDs.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_GOT_A = 3'd1,
        S_GOT_B = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Winning action after arbitration, listed in priority order.
    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_CLR  = 3'd1,
        ACT_A    = 3'd2,
        ACT_B    = 3'd3,
        ACT_F    = 3'd4
    } act_t;

    // Debounced single-cycle press pulses, one per button.
    typedef struct packed {
        logic clr;
        logic a;
        logic b;
        logic f;
    } press_t;

    // Fixed priority clr > a > b > f; losers are dropped without error.
    function automatic act_t arbitrate(input press_t p);
        act_t act;
        act = ACT_NONE;
        if (p.clr) begin
            act = ACT_CLR;
        end else if (p.a) begin
            act = ACT_A;
        end else if (p.b) begin
            act = ACT_B;
        end else if (p.f) begin
            act = ACT_F;
        end
        return act;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Button, ALU and display/LED signals of the ALU sequencing controller.
interface alu_seq_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         btn_a;
    logic         btn_b;
    logic         btn_f;
    logic         btn_clr;
    logic [W-1:0] alu_res;
    logic [3:0]   alu_flag;
    logic         ld_a;
    logic         ld_b;
    logic         ld_f;
    logic [W-1:0] res_q;
    logic [3:0]   flag_q;
    logic [2:0]   stage;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   op_cnt;

    modport master (
        output btn_a, btn_b, btn_f, btn_clr, alu_res, alu_flag,
        input  ld_a, ld_b, ld_f, res_q, flag_q, stage, busy, done, err, op_cnt
    );

    modport slave (
        input  btn_a, btn_b, btn_f, btn_clr, alu_res, alu_flag,
        output ld_a, ld_b, ld_f, res_q, flag_q, stage, busy, done, err, op_cnt
    );
endinterface

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// Synchronizes a raw button and emits one pulse per accepted press.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clk_rst,
    input  logic raw,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Two-flop sync, then flip the accepted level after DB_CYCLES differing samples.
    always_ff @(posedge clk) begin
        if (!clk_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences A/B/F loads for the lab3 ALU and captures its result and flags.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned W         = 32
) (
    input logic           clk,
    input logic           clk_rst,
    alu_seq_ctrl_if.slave bus
);
    press_t           press;
    act_t             act;
    state_t           state;
    state_t           state_d;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_d;
    logic             ld_a_q, ld_b_q, ld_f_q, err_q, done_q, busy_q;
    logic             ld_a_d, ld_b_d, ld_f_d, err_d, done_d, busy_d;
    logic [W-1:0]     res_q, res_d;
    logic [3:0]       flag_q, flag_d;
    logic [7:0]       op_cnt, op_d;
    logic             cap;
    logic             clr;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk(clk), .clk_rst(clk_rst), .raw(bus.btn_a), .press(press.a)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk(clk), .clk_rst(clk_rst), .raw(bus.btn_b), .press(press.b)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_f (
        .clk(clk), .clk_rst(clk_rst), .raw(bus.btn_f), .press(press.f)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .clk_rst(clk_rst), .raw(bus.btn_clr), .press(press.clr)
    );

    // Next state, load/err/done pulses, latency countdown and capture values.
    always_comb begin
        state_d = state;
        lat_d   = lat_cnt;
        ld_a_d  = 1'b0;
        ld_b_d  = 1'b0;
        ld_f_d  = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        cap     = 1'b0;
        clr     = 1'b0;
        act     = arbitrate(press);

        if (state == S_EXEC) begin
            lat_d = lat_cnt - LAT_W'(1);
            if (lat_cnt == LAT_W'(1)) begin
                cap     = 1'b1;
                state_d = S_DONE;
            end
        end

        case (act)
            ACT_CLR: begin
                clr     = 1'b1;
                cap     = 1'b0;
                state_d = S_IDLE;
            end
            ACT_A: begin
                if (state == S_EXEC) begin
                    err_d = 1'b1;
                end else begin
                    ld_a_d  = 1'b1;
                    state_d = S_GOT_A;
                end
            end
            ACT_B: begin
                if (state == S_IDLE || state == S_EXEC) begin
                    err_d = 1'b1;
                end else begin
                    ld_b_d  = 1'b1;
                    state_d = S_GOT_B;
                end
            end
            ACT_F: begin
                if (state == S_GOT_B || state == S_DONE) begin
                    ld_f_d  = 1'b1;
                    lat_d   = LAT_W'(ALU_LAT);
                    state_d = S_EXEC;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        done_d = cap;
        res_d  = res_q;
        flag_d = flag_q;
        op_d   = op_cnt;
        if (cap) begin
            res_d  = bus.alu_res;
            flag_d = bus.alu_flag;
            op_d   = op_cnt + 8'd1;
        end else if (clr) begin
            res_d  = '0;
            flag_d = '0;
        end
        busy_d = (state_d == S_EXEC);
    end

    // State, counter and registered output flops.
    always_ff @(posedge clk) begin
        if (!clk_rst) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            ld_a_q  <= 1'b0;
            ld_b_q  <= 1'b0;
            ld_f_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            flag_q  <= '0;
            op_cnt  <= '0;
        end else begin
            state   <= state_d;
            lat_cnt <= lat_d;
            ld_a_q  <= ld_a_d;
            ld_b_q  <= ld_b_d;
            ld_f_q  <= ld_f_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            op_cnt  <= op_d;
        end
    end

    assign bus.ld_a   = ld_a_q;
    assign bus.ld_b   = ld_b_q;
    assign bus.ld_f   = ld_f_q;
    assign bus.err    = err_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.res_q  = res_q;
    assign bus.flag_q = flag_q;
    assign bus.op_cnt = op_cnt;
    assign bus.stage  = state;
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller for the lab3 ALU datapath (operand A, operand B and opcode/F registers loaded from the shared 32-bit switch bus).
- Replaces the three raw button "clocks" with debounced, single-cycle load enables in the system clock domain.
- Enforces the legal order A, then B, then F, and waits out the ALU latency.
- Captures result and flags into stable registers for the 7-segment display and LEDs.

Parameters:
- DB_CYCLES, 1000000: cycles a button level must stay stable before it is accepted (10 ms at 100 MHz).
- ALU_LAT, 1: cycles from the ld_f pulse to a valid alu_res/alu_flag (legal range 1..15).
- W, 32: data width.

Ports:
- clk  in  1  system clock.
- clk_rst  in  1  synchronous, active-low reset.
- btn_a  in  1  raw asynchronous button: load A.
- btn_b  in  1  raw asynchronous button: load B.
- btn_f  in  1  raw asynchronous button: load opcode and execute.
- btn_clr  in  1  raw asynchronous button: abort and clear.
- alu_res  in  W  ALU result.
- alu_flag  in  4  ALU flags.
- ld_a  out  1  one-cycle load enable for A.
- ld_b  out  1  one-cycle load enable for B.
- ld_f  out  1  one-cycle load enable for the opcode.
- res_q  out  W  captured result, to the display.
- flag_q  out  4  captured flags, to the LEDs.
- stage  out  3  FSM state encoding, for debug LEDs.
- busy  out  1  high in S_EXEC.
- done  out  1  one-cycle pulse when a result is captured.
- err  out  1  one-cycle pulse when a press is rejected.
- op_cnt  out  8  count of completed operations.

Behaviour:
- Reset (clk_rst low at a clk edge):
  - state = S_IDLE.
  - All outputs 0: ld_*, res_q, flag_q, done, err, busy, op_cnt.
  - Debouncer counters and sync flops return to the released state.
  - Reset mid-S_EXEC abandons the operation; no capture and no done.
- Button conditioning (per button):
  - 2-FF synchronizer, then a stability counter.
  - The accepted level changes only after DB_CYCLES consecutive equal samples.
  - press = one-cycle pulse on the accepted 0->1 edge. No pulse on release; a held button yields exactly one press.
- Arbitration: at most one press acted on per cycle, priority clr > a > b > f. Lower-priority presses in the same cycle are dropped silently (no err).
- States: S_IDLE=0, S_GOT_A=1, S_GOT_B=2, S_EXEC=3, S_DONE=4.
- Transitions, action press -> effect:
  - Any state, clr: res_q=0, flag_q=0, go to S_IDLE. op_cnt is kept.
  - S_IDLE, a: ld_a, go to S_GOT_A. b or f: err.
  - S_GOT_A, a: ld_a, stay (reload). b: ld_b, go to S_GOT_B. f: err.
  - S_GOT_B, a: ld_a, go to S_GOT_A (restart). b: ld_b, stay. f: ld_f, load lat_cnt=ALU_LAT, go to S_EXEC.
  - S_EXEC, a/b/f: err, no load. Each cycle lat_cnt decrements. In the cycle lat_cnt==1:
    - res_q<=alu_res, flag_q<=alu_flag, done pulse.
    - op_cnt increments, wrapping 255->0.
    - Next state S_DONE.
  - S_DONE, a: ld_a, go to S_GOT_A. b: ld_b, go to S_GOT_B (A retained). f: ld_f, go to S_EXEC (re-execute with new opcode on the same A/B).
- Timing:
  - ld_*, err and done are registered, asserted the cycle after the press pulse.
  - Result capture occurs ALU_LAT cycles after the ld_f cycle.
  - res_q and flag_q change only at capture or clr.
- busy equals (state==S_EXEC). stage equals the state encoding.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum and encodings;
  - priority constant order;
  - LAT_W = 4.
- Sub-module btn_debounce, instantiated ×4:
  - parameter DB_CYCLES;
  - ports clk, clk_rst, raw, press.
  - Counter width $clog2(DB_CYCLES+1).
- Top-level holds the FSM, latency counter and capture registers.

Test Plan (sim with DB_CYCLES=4, ALU_LAT=2):
- Reset, then A press, B press, F press with alu_res=32'h0000_0007, alu_flag=4'b0010 -> one pulse each of ld_a, ld_b, ld_f; done 2 cycles after ld_f; res_q=7, flag_q=2, op_cnt=1, stage=4.
- Glitchy btn_a (high 2 cycles, low 1, high 6) -> exactly one ld_a, and only after 4 stable cycles.
- From S_IDLE press F, then B -> two err pulses, no ld_*, stage stays 0.
- btn_a and btn_f rise in the same cycle in S_GOT_B -> ld_a only, stage=1, no err.
- F press during S_EXEC -> err, no ld_f. Then btn_clr while busy -> S_IDLE, res_q=0, no done.
- 256 complete A/B/F sequences -> op_cnt wraps to 0. clk_rst low in S_EXEC -> all outputs 0 next cycle.
